// File: rtl/arith_sched.sv
// arith_sched: round-robin arbiter in front of one shared iterative arithmetic unit
// (single-cycle add/sub, A_W-cycle shift-add multiply); responses carry the requester id.
module arith_sched #(
  parameter int N_REQ = 4,
  parameter int A_W   = 5,
  parameter int M_W   = 10,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [N_REQ*A_W-1:0]   req_a,
  input  logic [N_REQ*A_W-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [M_W-1:0]         rsp_m,
  output logic                   busy
);

  localparam int                CNT_W    = $clog2(A_W) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(A_W - 1);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]     N_EXT    = (ID_W + 1)'(N_REQ);
  localparam logic [1:0]        OP_ADD   = 2'b00;
  localparam logic [1:0]        OP_SUB   = 2'b01;
  localparam logic [1:0]        OP_MUL   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ID_W-1:0]   rr_r;
  logic [1:0]        op_r;
  logic [A_W-1:0]    a_r;
  logic [A_W-1:0]    b_r;
  logic [ID_W-1:0]   id_r;
  logic [M_W-1:0]    acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [M_W-1:0]    rsp_m_r;
  logic [ID_W-1:0]   rsp_id_r;

  logic [1:0]        op_arr_s [N_REQ];
  logic [A_W-1:0]    a_arr_s  [N_REQ];
  logic [A_W-1:0]    b_arr_s  [N_REQ];
  logic [ID_W:0]     sum_s;
  logic [ID_W-1:0]   idx_s;
  logic              hit_s;
  logic              found_s;
  logic [ID_W-1:0]   grant_s;
  logic [ID_W-1:0]   rr_nxt_s;
  logic              accept_s;
  logic              exec_last_s;
  logic [M_W-1:0]    a_ext_s;
  logic [M_W-1:0]    b_ext_s;
  logic [M_W-1:0]    acc_s;

  // Round-robin search: first valid requester at or above rr, wrapping.
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    sum_s   = '0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      op_arr_s[k] = req_op[2*k +: 2];
      a_arr_s[k]  = req_a[A_W*k +: A_W];
      b_arr_s[k]  = req_b[A_W*k +: A_W];
    end
    for (int k = 0; k < N_REQ; k++) begin
      sum_s   = {1'b0, rr_r} + (ID_W + 1)'(k);
      idx_s   = (sum_s >= N_EXT) ? ID_W'(sum_s - N_EXT) : sum_s[ID_W-1:0];
      hit_s   = !found_s && req_valid[idx_s];
      grant_s = hit_s ? idx_s : grant_s;
      found_s = found_s | hit_s;
    end
  end

  // Ready is combinational so a request can be taken in the same cycle it appears.
  assign accept_s    = (state_r == ST_IDLE) && found_s && !rst;
  assign req_ready   = accept_s ? (N_REQ'(1) << grant_s) : '0;
  assign rr_nxt_s    = (grant_s == ID_LAST) ? '0 : grant_s + ID_W'(1);
  assign exec_last_s = (op_r != OP_MUL) || (cnt_r == CNT_LAST);
  assign a_ext_s     = {{(M_W - A_W){1'b0}}, a_r};
  assign b_ext_s     = {{(M_W - A_W){1'b0}}, b_r};

  // Next accumulator value for the current EXEC cycle.
  always_comb begin
    acc_s = '0;
    case (op_r)
      OP_ADD:  acc_s = a_ext_s + b_ext_s;
      OP_SUB:  acc_s = a_ext_s - b_ext_s;
      OP_MUL:  acc_s = b_r[0] ? (acc_r + (a_ext_s << cnt_r)) : acc_r;
      default: acc_s = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (exec_last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_r     <= '0;
      op_r     <= 2'b00;
      a_r      <= '0;
      b_r      <= '0;
      id_r     <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      rsp_m_r  <= '0;
      rsp_id_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r  <= op_arr_s[grant_s];
            a_r   <= a_arr_s[grant_s];
            b_r   <= b_arr_s[grant_s];
            id_r  <= grant_s;
            rr_r  <= rr_nxt_s;
            acc_r <= '0;
            cnt_r <= '0;
          end
        end
        ST_EXEC: begin
          acc_r <= acc_s;
          if (op_r == OP_MUL) begin
            b_r   <= b_r >> 1;
            cnt_r <= cnt_r + CNT_W'(1);
          end
          // Results live in their own registers so they hold through the next operation.
          if (exec_last_s) begin
            rsp_m_r  <= acc_s;
            rsp_id_r <= id_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid = (state_r == ST_DONE);
  assign busy      = (state_r != ST_IDLE);
  assign rsp_m     = rsp_m_r;
  assign rsp_id    = rsp_id_r;

endmodule

// File: tb/tb_arith_sched.sv
// Self-checking bench for arith_sched: scoreboard of expected {id, result} pushed on
// accept and popped when the response appears.
module tb_arith_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [19:0] req_a;
  logic [19:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [9:0]  rsp_m;
  logic        busy;

  logic [1:0]  op_arr [4];
  logic [4:0]  a_arr  [4];
  logic [4:0]  b_arr  [4];

  int          total = 0;
  int          bad   = 0;
  logic [11:0] exp_q [$];

  arith_sched #(.N_REQ(4), .A_W(5), .M_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_m     (rsp_m),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    for (int k = 0; k < 4; k++) begin
      req_op[2*k +: 2] = op_arr[k];
      req_a[5*k +: 5]  = a_arr[k];
      req_b[5*k +: 5]  = b_arr[k];
    end
  end

  function automatic logic [9:0] model(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    logic [9:0] ea;
    logic [9:0] eb;
    ea = {5'd0, a};
    eb = {5'd0, b};
    case (op)
      2'b00:   return ea + eb;
      2'b01:   return ea - eb;
      2'b10:   return ea * eb;
      default: return 10'd0;
    endcase
  endfunction

  task automatic drive_req(input logic [1:0] id, input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    op_arr[id]    = op;
    a_arr[id]     = a;
    b_arr[id]     = b;
    req_valid[id] = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request at a negedge, waits for its response and returns what was seen.
  task automatic run_op(input logic [1:0] id, input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        output logic [3:0] rdy, output int lat, output logic busy1, output bit got,
                        output logic [9:0] m, output logic [1:0] rid);
    drive_req(id, op, a, b);
    #1;
    rdy = req_ready;
    if (rdy[id]) exp_q.push_back({id, model(op, a, b)});
    @(negedge clk);
    req_valid[id] = 1'b0;
    busy1 = busy;
    lat = 1;
    got = 1'b0;
    m = '0;
    rid = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        m   = rsp_m;
        rid = rsp_id;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (got) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_m !== 10'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b valid=%b id=%0d m=%0d busy=%b, want all zero",
               req_ready, rsp_valid, rsp_id, rsp_m, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: got busy=%b valid=%b, want 0 0", busy, rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    logic [1:0] ids [3] = '{2'd0, 2'd0, 2'd1};
    logic [1:0] ops [3] = '{2'b00, 2'b01, 2'b11};
    logic [4:0] as  [3] = '{5'd31, 5'd3, 5'd9};
    logic [4:0] bs  [3] = '{5'd31, 5'd5, 5'd4};
    logic [9:0] lit [3] = '{10'd62, 10'h3FE, 10'd0};
    logic [3:0] rdy;
    int lat;
    logic busy1;
    bit got;
    logic [9:0] m;
    logic [1:0] rid;
    logic [11:0] e;
    for (int i = 0; i < 3; i++) begin
      run_op(ids[i], ops[i], as[i], bs[i], rdy, lat, busy1, got, m, rid);
      total++;
      if (rdy !== (4'b0001 << ids[i])) begin
        bad++;
        $display("FAIL addsub_ready[%0d]: got %b want %b", i, rdy, 4'b0001 << ids[i]);
      end
      total++;
      if (lat !== 2 || busy1 !== 1'b1) begin
        bad++;
        $display("FAIL addsub_latency[%0d]: got lat=%0d busy=%b want lat=2 busy=1", i, lat, busy1);
      end
      total++;
      if (!got || exp_q.size() == 0) begin
        bad++;
        $display("FAIL addsub_rsp[%0d]: got response=%0d queued=%0d, want a response", i, got, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (m !== e[9:0] || rid !== e[11:10] || m !== lit[i]) begin
          bad++;
          $display("FAIL addsub_rsp[%0d]: got m=%h id=%0d want m=%h id=%0d", i, m, rid, lit[i], e[11:10]);
        end
      end
    end
  endtask

  task automatic test_mul();
    logic [4:0] as  [3] = '{5'd31, 5'd0, 5'd1};
    logic [4:0] bs  [3] = '{5'd31, 5'd17, 5'd1};
    logic [9:0] lit [3] = '{10'd961, 10'd0, 10'd1};
    logic [3:0] rdy;
    int lat;
    logic busy1;
    bit got;
    logic [9:0] m;
    logic [1:0] rid;
    logic [11:0] e;
    for (int i = 0; i < 3; i++) begin
      run_op(2'd2, 2'b10, as[i], bs[i], rdy, lat, busy1, got, m, rid);
      total++;
      if (rdy !== 4'b0100 || lat !== 6) begin
        bad++;
        $display("FAIL mul_timing[%0d]: got ready=%b lat=%0d want ready=0100 lat=6", i, rdy, lat);
      end
      total++;
      if (!got || exp_q.size() == 0) begin
        bad++;
        $display("FAIL mul_rsp[%0d]: got response=%0d, want a response", i, got);
      end else begin
        e = exp_q.pop_front();
        if (m !== e[9:0] || rid !== 2'd2 || m !== lit[i]) begin
          bad++;
          $display("FAIL mul_rsp[%0d]: got m=%0d id=%0d want m=%0d id=2", i, m, rid, lit[i]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int grants = 0;
    int rsps = 0;
    logic [1:0] gid;
    logic [11:0] e;
    apply_reset();
    drive_req(2'd0, 2'b00, 5'd1, 5'd2);
    drive_req(2'd1, 2'b01, 5'd4, 5'd9);
    drive_req(2'd2, 2'b10, 5'd3, 5'd7);
    drive_req(2'd3, 2'b00, 5'd30, 5'd1);
    for (int c = 0; c < 80 && rsps < 5; c++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        total++;
        if (grants >= 5) begin
          bad++;
          $display("FAIL rr_extra_grant: got ready=%b want 0000", req_ready);
        end else begin
          gid = 2'(order[grants]);
          if (req_ready !== (4'b0001 << gid)) begin
            bad++;
            $display("FAIL rr_grant[%0d]: got %b want %b", grants, req_ready, 4'b0001 << gid);
          end
          exp_q.push_back({gid, model(op_arr[gid], a_arr[gid], b_arr[gid])});
          grants++;
        end
      end
      if (rsp_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rr_rsp_unexpected: got id=%0d m=%0d, want none", rsp_id, rsp_m);
        end else begin
          e = exp_q.pop_front();
          if (rsp_id !== e[11:10] || rsp_m !== e[9:0]) begin
            bad++;
            $display("FAIL rr_rsp[%0d]: got id=%0d m=%0d want id=%0d m=%0d", rsps, rsp_id, rsp_m, e[11:10], e[9:0]);
          end
        end
        rsps++;
      end
      @(negedge clk);
      if (grants == 5) req_valid = 4'b0000;
    end
    total++;
    if (grants != 5 || rsps != 5) begin
      bad++;
      $display("FAIL rr_counts: got grants=%0d rsps=%0d want 5 5", grants, rsps);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] e;
    int c;
    drive_req(2'd3, 2'b00, 5'd10, 5'd7);
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL bp_first_ready: got %b want 1000", req_ready);
    end
    exp_q.push_back({2'd3, model(2'b00, 5'd10, 5'd7)});
    @(negedge clk);
    req_valid[3] = 1'b0;
    rsp_ready = 1'b0;
    drive_req(2'd1, 2'b00, 5'd1, 5'd1);
    c = 0;
    while (rsp_valid !== 1'b1 && c < 10) begin
      @(negedge clk);
      c++;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_m !== e[9:0] || rsp_id !== e[11:10] || req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b m=%0d id=%0d ready=%b want 1 %0d %0d 0000",
                 i, rsp_valid, rsp_m, rsp_id, req_ready, e[9:0], e[11:10]);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_m !== e[9:0] || req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL bp_release: got busy=%b valid=%b m=%0d ready=%b want 0 0 %0d 0010",
               busy, rsp_valid, rsp_m, req_ready, e[9:0]);
    end
    exp_q.push_back({2'd1, model(2'b00, 5'd1, 5'd1)});
    @(negedge clk);
    req_valid[1] = 1'b0;
    c = 0;
    while (rsp_valid !== 1'b1 && c < 10) begin
      @(negedge clk);
      c++;
    end
    e = exp_q.pop_front();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== e[11:10] || rsp_m !== e[9:0]) begin
      bad++;
      $display("FAIL bp_second_rsp: got valid=%b id=%0d m=%0d want 1 %0d %0d", rsp_valid, rsp_id, rsp_m, e[11:10], e[9:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int nrsp = 0;
    logic [11:0] e;
    drive_req(2'd1, 2'b10, 5'd31, 5'd31);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_req(2'd0, 2'b00, 5'd5, 5'd6);
    drive_req(2'd1, 2'b01, 5'd9, 5'd2);
    drive_req(2'd2, 2'b00, 5'd3, 5'd3);
    drive_req(2'd3, 2'b01, 5'd8, 5'd1);
    #1;
    total++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_m !== 10'd0 || rsp_id !== 2'd0) begin
      bad++;
      $display("FAIL midmul_reset_outputs: got ready=%b valid=%b busy=%b m=%0d id=%0d want all zero",
               req_ready, rsp_valid, busy, rsp_m, rsp_id);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL midmul_first_grant: got %b want 0001", req_ready);
    end
    exp_q.push_back({2'd0, model(2'b00, 5'd5, 5'd6)});
    @(negedge clk);
    req_valid = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL midmul_rsp_unexpected: got id=%0d m=%0d want none", rsp_id, rsp_m);
        end else begin
          e = exp_q.pop_front();
          if (rsp_id !== e[11:10] || rsp_m !== e[9:0]) begin
            bad++;
            $display("FAIL midmul_rsp: got id=%0d m=%0d want id=%0d m=%0d", rsp_id, rsp_m, e[11:10], e[9:0]);
          end
        end
        nrsp++;
      end
      @(negedge clk);
    end
    total++;
    if (nrsp != 1) begin
      bad++;
      $display("FAIL midmul_rsp_count: got %0d want 1", nrsp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op_arr[k] = 2'b00;
      a_arr[k]  = 5'd0;
      b_arr[k]  = 5'd0;
    end
    test_reset();
    test_add_sub();
    test_mul();
    test_round_robin();
    test_backpressure();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
